dcpu16_ifb: RTL and testbench

DCPU16_IFB -- requirements
Module: dcpu16_ifb

---
 rtl/dcpu16_pkg.sv | 13 +
 rtl/dcpu16_ifq.sv | 45 ++++
 rtl/dcpu16_ifb.sv | 103 ++++++++++
 tb/tb_dcpu16_ifb.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/dcpu16_pkg.sv
// rtl/dcpu16_pkg.sv - shared types and constants for the DCPU16 instruction fetch buffer
package dcpu16_pkg;

    localparam int WORD_W    = 16;
    localparam int IFB_DEPTH = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        FLUSH = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/dcpu16_ifq.sv
// rtl/dcpu16_ifq.sv - circular prefetch queue with synchronous write and combinational head
module dcpu16_ifq
    import dcpu16_pkg::*;
#(
    parameter  int DEPTH = IFB_DEPTH,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              push,
    input  logic              pop,
    input  logic [WORD_W-1:0] din,
    output logic [WORD_W-1:0] head,
    output logic [CW-1:0]     count
);

    logic [WORD_W-1:0] mem [DEPTH];
    logic [AW-1:0]     rd_ptr;
    logic [AW-1:0]     wr_ptr;

    // DEPTH is a power of two, so the pointers wrap by natural overflow.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            count <= count + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (push && !clr)
            mem[wr_ptr] <= din;
    end

    assign head = mem[rd_ptr];

endmodule

// File: rtl/dcpu16_ifb.sv
// rtl/dcpu16_ifb.sv - instruction fetch buffer: prefetches words from memory into a small queue
module dcpu16_ifb
    import dcpu16_pkg::*;
#(
    parameter int DEPTH = IFB_DEPTH
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ena,
    output logic [WORD_W-1:0] fs_dti,
    output logic              fs_ack,
    output logic              fs_ena,
    output logic [WORD_W-1:0] pc,
    input  logic              pc_ld,
    input  logic [WORD_W-1:0] pc_dti,
    output logic [WORD_W-1:0] ib_adr,
    output logic              ib_stb,
    input  logic              ib_ack,
    input  logic [WORD_W-1:0] ib_dti
);

    localparam int CW = $clog2(DEPTH + 1);

    fetch_state_t      state;
    fetch_state_t      state_nxt;
    logic [WORD_W-1:0] fadr;
    logic [WORD_W-1:0] flush_adr;
    logic [WORD_W-1:0] head;
    logic [CW-1:0]     count;
    logic [CW-1:0]     cnt_after;
    logic              push;
    logic              pop;

    assign push      = (state == REQ) && ib_ack && !pc_ld;
    assign pop       = ena && fs_ack && !pc_ld;
    assign cnt_after = count + CW'(push) - CW'(pop);

    dcpu16_ifq #(
        .DEPTH(DEPTH)
    ) u_ifq (
        .clk   (clk),
        .rst   (rst),
        .clr   (pc_ld),
        .push  (push),
        .pop   (pop),
        .din   (ib_dti),
        .head  (head),
        .count (count)
    );

    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:  if (!pc_ld && count < CW'(DEPTH)) state_nxt = REQ;
            // A redirect that lands with the ack restarts immediately at the new target.
            REQ: begin
                if (ib_ack)
                    state_nxt = (pc_ld || cnt_after < CW'(DEPTH)) ? REQ : IDLE;
                else if (pc_ld)
                    state_nxt = FLUSH;
            end
            FLUSH: if (ib_ack) state_nxt = REQ;
            default: state_nxt = IDLE;
        endcase
    end

    // flush_adr keeps the abandoned read's address on the bus until memory answers it.
    always_ff @(posedge clk) begin
        if (rst) begin
            fadr      <= '0;
            flush_adr <= '0;
            pc        <= '0;
        end else if (pc_ld) begin
            fadr <= pc_dti;
            pc   <= pc_dti;
            if (state == REQ && !ib_ack)
                flush_adr <= fadr;
        end else begin
            if (push)
                fadr <= fadr + 1'b1;
            if (pop)
                pc <= pc + 1'b1;
        end
    end

    always_comb begin
        fs_ena = !rst;
        fs_ack = !rst && (count != '0);
        fs_dti = fs_ack ? head : '0;
        ib_stb = !rst && (state == REQ || state == FLUSH);
        ib_adr = '0;
        if (!rst)
            ib_adr = (state == FLUSH) ? flush_adr : fadr;
    end

endmodule

// File: tb/tb_dcpu16_ifb.sv
// tb/tb_dcpu16_ifb.sv - randomized self-checking bench for dcpu16_ifb against a queue-level model
module tb_dcpu16_ifb;

    localparam int DEPTH = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ena = 1'b0;
    logic        pc_ld = 1'b0;
    logic [15:0] pc_dti = '0;
    logic        ib_ack = 1'b0;
    logic [15:0] ib_dti = '0;
    logic [15:0] fs_dti;
    logic        fs_ack;
    logic        fs_ena;
    logic [15:0] pc;
    logic [15:0] ib_adr;
    logic        ib_stb;

    dcpu16_ifb #(.DEPTH(DEPTH)) dut (
        .clk    (clk),
        .rst    (rst),
        .ena    (ena),
        .fs_dti (fs_dti),
        .fs_ack (fs_ack),
        .fs_ena (fs_ena),
        .pc     (pc),
        .pc_ld  (pc_ld),
        .pc_dti (pc_dti),
        .ib_adr (ib_adr),
        .ib_stb (ib_stb),
        .ib_ack (ib_ack),
        .ib_dti (ib_dti)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // reference model: fetched words, program counter, next fetch address, bus status
    logic [15:0] m_q[$];
    logic [15:0] m_pc = '0;
    logic [15:0] m_fadr = '0;
    logic [15:0] m_bus_adr = '0;
    bit          m_busy = 0;
    bit          m_drop = 0;

    int          lat = 0;
    int          wcnt = 0;
    bit          inject = 0;
    bit          compare_on = 0;
    logic [15:0] ack_log[$];

    function automatic logic [15:0] mem_word(input logic [15:0] a);
        return a ^ 16'hA5C3;
    endfunction

    task automatic check16(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic compare();
        bit exp_ack;
        exp_ack = !rst && (m_q.size() > 0);
        check1("fs_ena", fs_ena, !rst);
        check1("fs_ack", fs_ack, exp_ack);
        check16("fs_dti", fs_dti, exp_ack ? m_q[0] : 16'h0000);
        check1("ib_stb", ib_stb, !rst && m_busy);
        if (rst)
            check16("ib_adr_rst", ib_adr, 16'h0000);
        else if (m_busy)
            check16("ib_adr", ib_adr, m_drop ? m_bus_adr : m_fadr);
        check16("pc", pc, m_pc);
    endtask

    function automatic void model_step(input bit r, input bit e, input bit pl,
                                       input logic [15:0] pd, input bit ack,
                                       input logic [15:0] dti);
        bit          do_pop;
        bit          was_busy;
        int          size0;
        logic [15:0] old_fadr;
        if (r) begin
            m_q.delete();
            m_pc = '0; m_fadr = '0; m_bus_adr = '0;
            m_busy = 0; m_drop = 0;
            return;
        end
        size0    = m_q.size();
        was_busy = m_busy;
        old_fadr = m_fadr;
        do_pop   = e && (size0 > 0) && !pl;
        if (was_busy && ack && !m_drop && !pl) begin
            m_q.push_back(dti);
            m_fadr = m_fadr + 16'd1;
        end
        if (do_pop) begin
            void'(m_q.pop_front());
            m_pc = m_pc + 16'd1;
        end
        if (pl) begin
            m_q.delete();
            m_pc = pd;
            m_fadr = pd;
        end
        if (!was_busy) begin
            m_busy = (size0 < DEPTH) && !pl;
        end else if (ack) begin
            m_busy = (m_drop || pl) ? 1'b1 : (m_q.size() < DEPTH);
            m_drop = 0;
        end else if (pl && !m_drop) begin
            m_drop = 1;
            m_bus_adr = old_fadr;
        end
    endfunction

    task automatic cycle(input bit r, input bit e, input bit pl, input logic [15:0] pd);
        @(negedge clk);
        rst = r; ena = e; pc_ld = pl; pc_dti = pd;
        #1;
        if (ib_stb) begin
            if (wcnt >= lat) begin
                ib_ack = 1'b1;
                ib_dti = mem_word(ib_adr);
                ack_log.push_back(ib_adr);
                wcnt = 0;
            end else begin
                ib_ack = 1'b0;
                ib_dti = 16'($urandom);
                wcnt++;
            end
        end else begin
            ib_ack = inject;
            ib_dti = 16'($urandom);
            inject = 0;
            wcnt = 0;
        end
        #1;
        if (compare_on)
            compare();
        model_step(r, e, pl, pd, ib_ack, ib_dti);
    endtask

    task automatic do_reset();
        for (int i = 0; i < 3; i++)
            cycle(1, 0, 0, 16'h0000);
        ack_log.delete();
    endtask

    initial begin
        logic [15:0] a0;
        logic [15:0] a1;
        bit          r;
        bit          e;
        bit          pl;
        logic [15:0] pd;

        cycle(1, 0, 0, 16'h0000);
        cycle(1, 0, 0, 16'h0000);
        compare_on = 1;
        do_reset();
        check1("rst_fs_ena", fs_ena, 1'b0);
        check1("rst_ib_stb", ib_stb, 1'b0);
        check16("rst_pc", pc, 16'h0000);

        // zero-wait streaming with ena held high
        lat = 0;
        cycle(0, 1, 0, 16'h0000);
        check1("first_stb_c0", ib_stb, 1'b0);
        cycle(0, 1, 0, 16'h0000);
        check1("first_stb_c1", ib_stb, 1'b1);
        check16("first_adr", ib_adr, 16'h0000);
        for (int i = 0; i < 20; i++)
            cycle(0, 1, 0, 16'h0000);
        check16("stream_pc", pc, 16'h0013);
        check16("stream_dti", fs_dti, 16'hA5D0);

        // redirect coinciding with an ack and a pop
        cycle(0, 1, 1, 16'h0400);
        cycle(0, 1, 0, 16'h0000);
        check1("ldack_empty", fs_ack, 1'b0);
        check1("ldack_stb", ib_stb, 1'b1);
        check16("ldack_adr", ib_adr, 16'h0400);
        check16("ldack_pc", pc, 16'h0400);

        // fill with ena low, then resume
        do_reset();
        for (int i = 0; i < 10; i++)
            cycle(0, 0, 0, 16'h0000);
        check16("fill_acks", 16'(ack_log.size()), 16'd2);
        check1("fill_stb", ib_stb, 1'b0);
        check1("fill_ack", fs_ack, 1'b1);
        check16("fill_dti", fs_dti, 16'hA5C3);
        cycle(0, 1, 0, 16'h0000);
        for (int i = 0; i < 3; i++)
            cycle(0, 0, 0, 16'h0000);
        check16("resume_acks", 16'(ack_log.size()), 16'd3);
        check16("resume_adr", ack_log[ack_log.size()-1], 16'h0002);

        // redirect to the top of the address space
        cycle(0, 0, 1, 16'hFFFF);
        for (int i = 0; i < 4; i++)
            cycle(0, 0, 0, 16'h0000);
        a0 = ack_log[ack_log.size()-2];
        a1 = ack_log[ack_log.size()-1];
        check16("wrap_adr0", a0, 16'hFFFF);
        check16("wrap_adr1", a1, 16'h0000);
        check16("wrap_dti0", fs_dti, 16'h5A3C);
        check16("wrap_pc0", pc, 16'hFFFF);
        cycle(0, 1, 0, 16'h0000);
        cycle(0, 0, 0, 16'h0000);
        check16("wrap_pc1", pc, 16'h0000);
        check16("wrap_dti1", fs_dti, 16'hA5C3);

        // reset mid-request, stray late ack, then redirect before ack
        do_reset();
        lat = 3;
        cycle(0, 0, 0, 16'h0000);
        cycle(0, 0, 0, 16'h0000);
        cycle(0, 0, 0, 16'h0000);
        cycle(1, 0, 0, 16'h0000);
        check1("rst_drop_stb", ib_stb, 1'b0);
        ack_log.delete();
        inject = 1;
        cycle(0, 0, 0, 16'h0000);
        cycle(0, 0, 0, 16'h0000);
        check1("late_ack_ignored", fs_ack, 1'b0);
        cycle(0, 0, 1, 16'h1234);
        for (int i = 0; i < 20; i++) begin
            cycle(0, 0, 0, 16'h0000);
            if (fs_ack)
                break;
        end
        check1("flush_done", fs_ack, 1'b1);
        check16("flush_dti", fs_dti, 16'hB7F7);
        check16("flush_pc", pc, 16'h1234);
        check16("flush_stale_adr", (ack_log.size() > 0) ? ack_log[0] : 16'hDEAD, 16'h0000);
        check16("flush_new_adr", (ack_log.size() > 1) ? ack_log[1] : 16'hDEAD, 16'h1234);

        // randomized traffic
        do_reset();
        for (int i = 0; i < 4000; i++) begin
            if (i % 50 == 0)
                lat = $urandom_range(0, 3);
            r  = ($urandom_range(0, 199) == 0);
            e  = ($urandom_range(0, 3) != 0);
            pl = ($urandom_range(0, 15) == 0);
            case ($urandom_range(0, 3))
                0:       pd = 16'hFFFF;
                1:       pd = 16'hFFFE;
                default: pd = 16'($urandom);
            endcase
            cycle(r, e, pl, pd);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
